regfile_mp: RTL and testbench

//   Parametrised multi-port CPU register file: 2 async read ports, 2 write ports, optional

---
 rtl/regfile_mp_if.sv | 34 +++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file port bundle: stall, read, write, scoreboard and ready signals
// Ports: delay, rin1/rout1/rbusy1, rin2/rout2/rbusy2, we0/waddr0/win0, we1/waddr1/win1,
//        bset/bset_addr, ready. The master modport drives requests; the slave modport is the register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              delay;
    logic [ADDR_W-1:0] rin1;
    logic [DATA_W-1:0] rout1;
    logic              rbusy1;
    logic [ADDR_W-1:0] rin2;
    logic [DATA_W-1:0] rout2;
    logic              rbusy2;
    logic              we0;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] win0;
    logic              we1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] win1;
    logic              bset;
    logic [ADDR_W-1:0] bset_addr;
    logic              ready;

    modport master (
        output delay, rin1, rin2, we0, waddr0, win0, we1, waddr1, win1, bset, bset_addr,
        input  rout1, rbusy1, rout2, rbusy2, ready
    );

    modport slave (
        input  delay, rin1, rin2, we0, waddr0, win0, we1, waddr1, win1, bset, bset_addr,
        output rout1, rbusy1, rout2, rbusy2, ready
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, busy scoreboard and post-reset clear sweep
// Ports: clk, reset (sync active-high), bus (regfile_mp_if.slave): 2 async reads with busy flags,
//        2 write ports (port 1 wins collisions), bset scoreboard marking, delay stall, ready.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        reset,
    regfile_mp_if.slave bus
);
    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_ready;
    logic [NREGS-1:0]  r_busy;
    logic [DATA_W-1:0] r_mem [NREGS];

    logic              w_active;
    logic              w_wr0;
    logic              w_wr1;
    logic              w_bset;
    logic              w_fwd;
    logic [NREGS-1:0]  w_busy_next;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_active = (r_state == S_RUN) && !bus.delay;
    // Writes and busy marks aimed at the hardwired zero register are dropped.
    assign w_wr0  = w_active && bus.we0  && !((ZERO_REG != 0) && (bus.waddr0 == '0));
    assign w_wr1  = w_active && bus.we1  && !((ZERO_REG != 0) && (bus.waddr1 == '0));
    assign w_bset = w_active && bus.bset && !((ZERO_REG != 0) && (bus.bset_addr == '0));
    assign w_fwd  = (BYPASS != 0) && w_active;

    // Set is applied last so a newly issued producer outranks a retiring one.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr0)  w_busy_next[bus.waddr0]    = 1'b0;
        if (w_wr1)  w_busy_next[bus.waddr1]    = 1'b0;
        if (w_bset) w_busy_next[bus.bset_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_ready <= 1'b0;
            r_busy  <= '0;
        end else if (!bus.delay) begin
            case (r_state)
                S_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (&r_ptr) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN: r_busy <= w_busy_next;
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    // The array has no reset; the sweep zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (!reset && !bus.delay) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_ptr] <= '0;
            end else begin
                if (w_wr0) r_mem[bus.waddr0] <= bus.win0;
                if (w_wr1) r_mem[bus.waddr1] <= bus.win1;
            end
        end
    end

    always_comb begin
        w_rd1 = r_mem[bus.rin1];
        if (w_fwd && bus.we1 && (bus.waddr1 == bus.rin1))      w_rd1 = bus.win1;
        else if (w_fwd && bus.we0 && (bus.waddr0 == bus.rin1)) w_rd1 = bus.win0;
        if (r_state != S_RUN || ((ZERO_REG != 0) && (bus.rin1 == '0))) w_rd1 = '0;
    end

    always_comb begin
        w_rd2 = r_mem[bus.rin2];
        if (w_fwd && bus.we1 && (bus.waddr1 == bus.rin2))      w_rd2 = bus.win1;
        else if (w_fwd && bus.we0 && (bus.waddr0 == bus.rin2)) w_rd2 = bus.win0;
        if (r_state != S_RUN || ((ZERO_REG != 0) && (bus.rin2 == '0))) w_rd2 = '0;
    end

    assign bus.rout1  = w_rd1;
    assign bus.rout2  = w_rd2;
    assign bus.rbusy1 = (r_state == S_RUN) && r_busy[bus.rin1];
    assign bus.rbusy2 = (r_state == S_RUN) && r_busy[bus.rin2];
    assign bus.ready  = r_ready;
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp with a behavioural model
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: number of entries cleared so far; file usable once all 32 are cleared.
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    int          m_cleared = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (m_cleared < 32 || a == 5'd0) return 32'd0;
        if (!bus.delay && bus.we1 && bus.waddr1 == a) return bus.win1;
        if (!bus.delay && bus.we0 && bus.waddr0 == a) return bus.win0;
        return m_mem[a];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a);
        return (m_cleared == 32) ? m_busy[a] : 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cleared = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (!bus.delay) begin
            if (m_cleared < 32) begin
                m_mem[m_cleared] = 32'd0;
                m_cleared++;
            end else begin
                if (bus.we0 && bus.waddr0 != 0) begin
                    m_mem[bus.waddr0] = bus.win0;
                    m_busy[bus.waddr0] = 1'b0;
                end
                if (bus.we1 && bus.waddr1 != 0) begin
                    m_mem[bus.waddr1] = bus.win1;
                    m_busy[bus.waddr1] = 1'b0;
                end
                if (bus.bset && bus.bset_addr != 0) m_busy[bus.bset_addr] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_rout1",  bus.rout1,  m_read(bus.rin1));
            chk("cmp_rout2",  bus.rout2,  m_read(bus.rin2));
            chk("cmp_rbusy1", {31'd0, bus.rbusy1}, {31'd0, m_rbusy(bus.rin1)});
            chk("cmp_rbusy2", {31'd0, bus.rbusy2}, {31'd0, m_rbusy(bus.rin2)});
            chk("cmp_ready",  {31'd0, bus.ready},  {31'd0, (m_cleared == 32)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.delay = 0; bus.we0 = 0; bus.we1 = 0; bus.bset = 0;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!bus.ready && n < 200) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, bus.ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        idle();
        bus.rin1 = 0; bus.rin2 = 0; bus.waddr0 = 0; bus.waddr1 = 0;
        bus.win0 = 0; bus.win1 = 0; bus.bset_addr = 0;

        // 1: sweep with a 3-cycle stall takes 35 cycles
        rst = 1; tick(); rst = 0;
        chk_en = 1'b1;
        chk("reset_ready", {31'd0, bus.ready}, 32'd0);
        cyc = 0;
        while (!bus.ready && cyc < 100) begin
            bus.delay = (cyc >= 10 && cyc < 13);
            tick();
            cyc++;
        end
        bus.delay = 0;
        chk("sweep_cycles", cyc, 32'd35);
        for (int i = 0; i < 32; i++) begin
            bus.rin1 = 5'(i); bus.rin2 = 5'(31 - i); #1;
            chk("sweep_zero1", bus.rout1, 32'd0);
            chk("sweep_zero2", bus.rout2, 32'd0);
        end

        // 2: write collision, port 1 wins, with bypass
        bus.we0 = 1; bus.waddr0 = 5; bus.win0 = 32'h1234;
        bus.we1 = 1; bus.waddr1 = 5; bus.win1 = 32'hBEEF;
        bus.rin1 = 5; #1;
        chk("collide_bypass", bus.rout1, 32'hBEEF);
        tick(); idle(); #1;
        chk("collide_stored", bus.rout1, 32'hBEEF);

        // 3: zero register
        bus.we0 = 1; bus.waddr0 = 0; bus.win0 = 32'hFFFF_FFFF; bus.rin1 = 0; #1;
        chk("r0_same", bus.rout1, 32'd0);
        tick(); idle(); #1;
        chk("r0_next", bus.rout1, 32'd0);

        // 4: scoreboard
        bus.bset = 1; bus.bset_addr = 7; bus.rin1 = 7;
        tick(); idle(); #1;
        chk("busy_set", {31'd0, bus.rbusy1}, 32'd1);
        bus.we0 = 1; bus.waddr0 = 7; bus.win0 = 32'hA; #1;
        chk("busy_regd", {31'd0, bus.rbusy1}, 32'd1);
        tick(); idle(); #1;
        chk("busy_clr", {31'd0, bus.rbusy1}, 32'd0);
        bus.bset = 1; bus.bset_addr = 7; bus.we1 = 1; bus.waddr1 = 7; bus.win1 = 32'hC;
        tick(); idle(); #1;
        chk("busy_setwins", {31'd0, bus.rbusy1}, 32'd1);
        chk("busy_setwins_data", bus.rout1, 32'hC);

        // 5: stall freezes writes and busy, disables bypass
        bus.we0 = 1; bus.waddr0 = 3; bus.win0 = 32'h11;
        tick(); idle();
        bus.delay = 1; bus.we0 = 1; bus.waddr0 = 3; bus.win0 = 32'h55;
        bus.bset = 1; bus.bset_addr = 4; bus.rin1 = 3; bus.rin2 = 4; #1;
        chk("stall_nobypass", bus.rout1, 32'h11);
        tick(); idle(); #1;
        chk("stall_data", bus.rout1, 32'h11);
        chk("stall_busy", {31'd0, bus.rbusy2}, 32'd0);

        // 6: reset mid-run
        bus.we0 = 1; bus.waddr0 = 9; bus.win0 = 32'h77; bus.bset = 1; bus.bset_addr = 9;
        bus.rin1 = 9;
        tick(); idle(); #1;
        chk("r9_busy", {31'd0, bus.rbusy1}, 32'd1);
        chk("r9_data", bus.rout1, 32'h77);
        rst = 1; tick(); rst = 0; #1;
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_busy", {31'd0, bus.rbusy1}, 32'd0);
        chk("rst_rout", bus.rout1, 32'd0);
        wait_ready("rst_sweep_done");
        #1;
        chk("r9_cleared", bus.rout1, 32'd0);
        chk("r9_notbusy", {31'd0, bus.rbusy1}, 32'd0);

        // Random traffic with addresses concentrated on 0..15 to provoke collisions
        for (int k = 0; k < 3000; k++) begin
            rst           = ($urandom % 400) == 0;
            bus.delay     = ($urandom % 8) == 0;
            bus.we0       = $urandom % 2;
            bus.waddr0    = 5'($urandom_range(0, 15));
            bus.win0      = $urandom;
            bus.we1       = $urandom % 2;
            bus.waddr1    = 5'($urandom_range(0, 15));
            bus.win1      = $urandom;
            bus.bset      = ($urandom % 3) == 0;
            bus.bset_addr = 5'($urandom_range(0, 15));
            bus.rin1      = 5'($urandom_range(0, 15));
            bus.rin2      = 5'($urandom_range(0, 31));
            tick();
        end
        rst = 0; idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
